// File: rtl/seq_borrow_lookahead_sub.sv
// Multi-cycle WIDTH-bit subtractor (diff = A - B - Bin), one 4-bit borrow-lookahead nibble per clock.
// Optional signed-overflow flag enabled by defining SUB_OVF_EN.
module seq_borrow_lookahead_sub #(
  parameter int unsigned WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic             Bin,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] diff,
  output logic             Bout,
  output logic             ovf
);

  localparam int unsigned N  = WIDTH / 4;
  localparam int unsigned KW = (N > 1) ? $clog2(N) : 1;
  localparam logic [KW-1:0] LAST = KW'(N - 1);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] a_q, a_d, b_q, b_d, res_q, res_d, diff_q, diff_d;
  logic [KW-1:0]    k_q, k_d;
  logic             c_q, c_d, bout_q, bout_d, busy_q, busy_d, done_q, done_d;

  logic [3:0] na, nb, g, p, nd;
  logic [4:0] c;

  assign na = a_q[{k_q, 2'b00} +: 4];
  assign nb = b_q[{k_q, 2'b00} +: 4];
  assign g  = ~na & nb;
  assign p  = ~(na ^ nb);

  // Borrows flattened to two-level lookahead form rather than rippled.
  assign c[0] = c_q;
  assign c[1] = g[0] | (p[0] & c[0]);
  assign c[2] = g[1] | (p[1] & g[0]) | (p[1] & p[0] & c[0]);
  assign c[3] = g[2] | (p[2] & g[1]) | (p[2] & p[1] & g[0]) | (p[2] & p[1] & p[0] & c[0]);
  assign c[4] = g[3] | (p[3] & g[2]) | (p[3] & p[2] & g[1]) | (p[3] & p[2] & p[1] & g[0])
              | (p[3] & p[2] & p[1] & p[0] & c[0]);
  assign nd   = na ^ nb ^ c[3:0];

`ifdef SUB_OVF_EN
  logic ovf_q, ovf_d;
`endif

  always_comb begin
    state_d = state_q;
    a_d     = a_q;
    b_d     = b_q;
    c_d     = c_q;
    k_d     = k_q;
    res_d   = res_q;
    diff_d  = diff_q;
    bout_d  = bout_q;
`ifdef SUB_OVF_EN
    ovf_d   = ovf_q;
`endif
    case (state_q)
      IDLE: begin
        if (start) begin
          a_d     = A;
          b_d     = B;
          c_d     = Bin;
          k_d     = '0;
          res_d   = '0;
          state_d = RUN;
        end
      end
      RUN: begin
        res_d[{k_q, 2'b00} +: 4] = nd;
        c_d = c[4];
        k_d = k_q + 1'b1;
        if (k_q == LAST) begin
          k_d     = '0;
          diff_d  = res_d;
          bout_d  = c[4];
`ifdef SUB_OVF_EN
          ovf_d   = (a_q[WIDTH-1] ^ b_q[WIDTH-1]) & (res_d[WIDTH-1] ^ a_q[WIDTH-1]);
`endif
          state_d = DONE;
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
    busy_d = (state_d != IDLE);
    done_d = (state_d == DONE);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      a_q     <= '0;
      b_q     <= '0;
      c_q     <= 1'b0;
      k_q     <= '0;
      res_q   <= '0;
      diff_q  <= '0;
      bout_q  <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      a_q     <= a_d;
      b_q     <= b_d;
      c_q     <= c_d;
      k_q     <= k_d;
      res_q   <= res_d;
      diff_q  <= diff_d;
      bout_q  <= bout_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

`ifdef SUB_OVF_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) ovf_q <= 1'b0;
    else        ovf_q <= ovf_d;
  end
  assign ovf = ovf_q;
`else
  assign ovf = 1'b0;
`endif

  assign busy = busy_q;
  assign done = done_q;
  assign diff = diff_q;
  assign Bout = bout_q;

endmodule

// File: tb/tb_seq_borrow_lookahead_sub.sv
// Directed, table-driven bench for seq_borrow_lookahead_sub at WIDTH = 16.
// Expected ovf follows SUB_OVF_EN the same way as the design build.
module tb_seq_borrow_lookahead_sub;

  localparam int unsigned WIDTH = 16;
  localparam int unsigned N     = WIDTH / 4;

  logic             clk, rst_n, start, Bin;
  logic [WIDTH-1:0] A, B;
  logic             busy, done, Bout, ovf;
  logic [WIDTH-1:0] diff;

  int unsigned n_checks = 0;
  int unsigned n_fail   = 0;
  logic [WIDTH-1:0] prev_diff;

  seq_borrow_lookahead_sub #(.WIDTH(WIDTH)) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .start(start),
    .A    (A),
    .B    (B),
    .Bin  (Bin),
    .busy (busy),
    .done (done),
    .diff (diff),
    .Bout (Bout),
    .ovf  (ovf)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             bin;
    logic [WIDTH-1:0] exp_diff;
    logic             exp_bout;
    logic             exp_ovf;  // value when overflow detection is built in
  } vec_t;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  function automatic logic ovf_expect(input logic v);
`ifdef SUB_OVF_EN
    return v;
`else
    return 1'b0 & v;
`endif
  endfunction

  // One full operation with timing checks; operands are scrambled after E0 to prove latching.
  task automatic run_vec(input vec_t v, input string tag);
    int unsigned dones    = 0;
    int unsigned busy_bad = 0;
    @(negedge clk);
    A = v.a; B = v.b; Bin = v.bin; start = 1'b1;
    @(negedge clk);                       // after E0
    start = 1'b0; A = 16'hDEAD; B = 16'hBEEF; Bin = ~v.bin;
    if (busy !== 1'b1) busy_bad++;
    if (done === 1'b1) dones++;
    for (int unsigned i = 1; i <= N + 1; i++) begin
      @(negedge clk);                     // after E_i
      if (done === 1'b1) dones++;
      if (i <= N && busy !== 1'b1) busy_bad++;
      if (i == N - 1) check({tag, " diff_held_before_done"}, 32'(diff), 32'(prev_diff));
      if (i == N) begin
        check({tag, " done_at_EN"}, 32'(done), 32'd1);
        check({tag, " diff"}, 32'(diff), 32'(v.exp_diff));
        check({tag, " Bout"}, 32'(Bout), 32'(v.exp_bout));
        check({tag, " ovf"},  32'(ovf),  32'(ovf_expect(v.exp_ovf)));
      end
      if (i == N + 1) begin
        check({tag, " busy_low_after_EN1"}, 32'(busy), 32'd0);
        check({tag, " diff_held_after_done"}, 32'(diff), 32'(v.exp_diff));
      end
    end
    check({tag, " busy_window"}, busy_bad, 32'd0);
    check({tag, " done_count"}, dones, 32'd1);
    prev_diff = v.exp_diff;
  endtask

  vec_t vecs[9];

  initial begin
    int unsigned dones;
    vecs[0] = '{16'h1234, 16'h0234, 1'b0, 16'h1000, 1'b0, 1'b0};
    vecs[1] = '{16'h0000, 16'h0001, 1'b0, 16'hFFFF, 1'b1, 1'b0};
    vecs[2] = '{16'h1000, 16'h0000, 1'b1, 16'h0FFF, 1'b0, 1'b0};
    vecs[3] = '{16'h8000, 16'h0001, 1'b0, 16'h7FFF, 1'b0, 1'b1};
    vecs[4] = '{16'h5A5A, 16'h5A5A, 1'b1, 16'hFFFF, 1'b1, 1'b0};
    vecs[5] = '{16'h7FFF, 16'hFFFF, 1'b0, 16'h8000, 1'b1, 1'b1};
    vecs[6] = '{16'hFFFF, 16'hFFFF, 1'b0, 16'h0000, 1'b0, 1'b0};
    vecs[7] = '{16'hABCD, 16'h1234, 1'b0, 16'h9999, 1'b0, 1'b0};
    vecs[8] = '{16'h0000, 16'hFFFF, 1'b1, 16'h0000, 1'b1, 1'b0};

    rst_n = 1'b0; start = 1'b0; A = '0; B = '0; Bin = 1'b0;
    prev_diff = '0;
    repeat (2) @(negedge clk);
    check("reset busy", 32'(busy), 32'd0);
    check("reset done", 32'(done), 32'd0);
    check("reset diff", 32'(diff), 32'd0);
    check("reset Bout", 32'(Bout), 32'd0);
    check("reset ovf",  32'(ovf),  32'd0);
    rst_n = 1'b1;

    foreach (vecs[i]) run_vec(vecs[i], $sformatf("vec%0d", i));

    // A start pulse during RUN is dropped, not queued.
    dones = 0;
    @(negedge clk);
    A = 16'h0005; B = 16'h0003; Bin = 1'b0; start = 1'b1;
    @(negedge clk);                       // after E0
    start = 1'b0;
    @(negedge clk);                       // after E1
    A = 16'hFFFF; B = 16'h0001; start = 1'b1;
    @(negedge clk);                       // after E2 sampled the stray start
    start = 1'b0;
    for (int unsigned i = 0; i < 10; i++) begin
      if (done === 1'b1) dones++;
      @(negedge clk);
    end
    check("ignore done_count", dones, 32'd1);
    check("ignore diff", 32'(diff), 32'h0002);
    check("ignore Bout", 32'(Bout), 32'd0);
    check("ignore busy_idle", 32'(busy), 32'd0);
    prev_diff = 16'h0002;

    // Asynchronous reset between E2 and E3 aborts the operation.
    dones = 0;
    @(negedge clk);
    A = 16'h1234; B = 16'h0234; Bin = 1'b0; start = 1'b1;
    @(negedge clk);                       // after E0
    start = 1'b0;
    repeat (2) @(negedge clk);            // after E2
    #2 rst_n = 1'b0;
    #1;
    check("midreset busy", 32'(busy), 32'd0);
    check("midreset diff", 32'(diff), 32'd0);
    check("midreset done", 32'(done), 32'd0);
    for (int unsigned i = 0; i < 4; i++) begin
      @(negedge clk);
      if (done === 1'b1) dones++;
    end
    rst_n = 1'b1;
    for (int unsigned i = 0; i < 4; i++) begin
      @(negedge clk);
      if (done === 1'b1) dones++;
    end
    check("midreset no_done", dones, 32'd0);
    check("midreset idle", 32'(busy), 32'd0);
    check("midreset Bout", 32'(Bout), 32'd0);
    prev_diff = '0;
    run_vec(vecs[0], "post_reset");

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation exceeded time limit");
    $fatal(1, "timeout");
  end

endmodule
